// File: rtl/ssd_scan_controller.sv
// ssd_scan_controller: multiplexed seven-segment scanner with staged display
// updates committed at frame boundaries, leading-zero suppression and PWM dimming.
module ssd_scan_controller #(
    parameter int N_DIGITS   = 8,
    parameter int PRESCALE_W = 17,
    parameter int PWM_W      = 4
) (
    input  logic                  board_clk,
    input  logic                  Reset,
    input  logic [4*N_DIGITS-1:0] value,
    input  logic [N_DIGITS-1:0]   dp,
    input  logic [N_DIGITS-1:0]   blank,
    input  logic                  lz_suppress,
    input  logic [PWM_W-1:0]      brightness,
    input  logic                  load,
    output logic                  load_ack,
    output logic                  frame_start,
    output logic [N_DIGITS-1:0]   an,
    output logic [7:0]            cathodes
);
    localparam int IW = $clog2(N_DIGITS);

    logic [PRESCALE_W-1:0] presc_q, presc_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic                  pend_q, pend_d;
    logic [4*N_DIGITS-1:0] stg_val_q, stg_val_d, act_val_q, act_val_d;
    logic [N_DIGITS-1:0]   stg_dp_q, stg_dp_d, act_dp_q, act_dp_d;
    logic [N_DIGITS-1:0]   stg_blank_q, stg_blank_d, act_blank_q, act_blank_d;
    logic                  load_ack_q, load_ack_d, frame_start_q, frame_start_d;
    logic [N_DIGITS-1:0]   an_q, an_d;
    logic [7:0]            cath_q, cath_d;

    logic                  tick, boundary, commit;
    logic [3:0]            nib;
    logic                  cur_dp, cur_blank, cur_sup, zero_run, enabled, dark;
    logic [PWM_W-1:0]      phase;

    // Active-low {a,b,c,d,e,f,g}
    function automatic logic [6:0] seg7(input logic [3:0] h);
        case (h)
            4'h0: seg7 = 7'b0000001;
            4'h1: seg7 = 7'b1001111;
            4'h2: seg7 = 7'b0010010;
            4'h3: seg7 = 7'b0000110;
            4'h4: seg7 = 7'b1001100;
            4'h5: seg7 = 7'b0100100;
            4'h6: seg7 = 7'b0100000;
            4'h7: seg7 = 7'b0001111;
            4'h8: seg7 = 7'b0000000;
            4'h9: seg7 = 7'b0000100;
            4'hA: seg7 = 7'b0001000;
            4'hB: seg7 = 7'b1100000;
            4'hC: seg7 = 7'b0110001;
            4'hD: seg7 = 7'b1000010;
            4'hE: seg7 = 7'b0110000;
            default: seg7 = 7'b0111000;
        endcase
    endfunction

    always_ff @(posedge board_clk or posedge Reset) begin
        if (Reset) begin
            presc_q       <= '0;
            idx_q         <= '0;
            pend_q        <= 1'b0;
            stg_val_q     <= '0;
            stg_dp_q      <= '0;
            stg_blank_q   <= '1;
            act_val_q     <= '0;
            act_dp_q      <= '0;
            act_blank_q   <= '1;
            load_ack_q    <= 1'b0;
            frame_start_q <= 1'b0;
            an_q          <= '1;
            cath_q        <= 8'hFF;
        end else begin
            presc_q       <= presc_d;
            idx_q         <= idx_d;
            pend_q        <= pend_d;
            stg_val_q     <= stg_val_d;
            stg_dp_q      <= stg_dp_d;
            stg_blank_q   <= stg_blank_d;
            act_val_q     <= act_val_d;
            act_dp_q      <= act_dp_d;
            act_blank_q   <= act_blank_d;
            load_ack_q    <= load_ack_d;
            frame_start_q <= frame_start_d;
            an_q          <= an_d;
            cath_q        <= cath_d;
        end
    end

    // A load at a committing boundary lands in staging after the old staging moves out
    always_comb begin
        tick          = &presc_q;
        boundary      = tick && (idx_q == IW'(N_DIGITS - 1));
        commit        = boundary && pend_q;
        presc_d       = presc_q + PRESCALE_W'(1);
        idx_d         = !tick ? idx_q : (boundary ? '0 : idx_q + IW'(1));
        stg_val_d     = load ? value : stg_val_q;
        stg_dp_d      = load ? dp : stg_dp_q;
        stg_blank_d   = load ? blank : stg_blank_q;
        pend_d        = load || (pend_q && !commit);
        act_val_d     = commit ? stg_val_q : act_val_q;
        act_dp_d      = commit ? stg_dp_q : act_dp_q;
        act_blank_d   = commit ? stg_blank_q : act_blank_q;
        load_ack_d    = commit;
        frame_start_d = boundary;
    end

    always_comb begin
        nib       = 4'h0;
        cur_dp    = 1'b0;
        cur_blank = 1'b1;
        cur_sup   = 1'b0;
        zero_run  = 1'b1;
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            zero_run = zero_run && (act_val_q[4*i +: 4] == 4'h0);
            if (idx_q == IW'(i)) begin
                nib       = act_val_q[4*i +: 4];
                cur_dp    = act_dp_q[i];
                cur_blank = act_blank_q[i];
                cur_sup   = (i != 0) && zero_run && !act_dp_q[i];
            end
        end
        phase   = presc_q[PRESCALE_W-1 -: PWM_W];
        enabled = (&brightness) || (phase < brightness);
        dark    = !enabled || cur_blank || (lz_suppress && cur_sup);
        an_d    = dark ? '1 : ~(N_DIGITS'(1) << idx_q);
        cath_d  = dark ? 8'hFF : {seg7(nib), ~cur_dp};
    end

    assign load_ack    = load_ack_q;
    assign frame_start = frame_start_q;
    assign an          = an_q;
    assign cathodes    = cath_q;
endmodule

// File: doc/ssd_scan_controller.md
SSD_SCAN_CONTROLLER -- requirements
Module: ssd_scan_controller

Interface
REQ-001 Parameter N_DIGITS, default 8, number of multiplexed seven-segment digits; legal range 2..16.
REQ-002 Parameter PRESCALE_W, default 17, scan-tick prescaler width; a tick occurs every 2^PRESCALE_W clocks; PRESCALE_W >= PWM_W+1.
REQ-003 Parameter PWM_W, default 4, brightness resolution in bits.
REQ-004 board_clk  input  1  system clock; all state on its rising edge.
REQ-005 Reset  input  1  asynchronous, active-high reset.
REQ-006 value  input  4*N_DIGITS  hex nibble per digit; digit i = value[4i+3:4i]; digit 0 rightmost.
REQ-007 dp  input  N_DIGITS  decimal point per digit, 1 = lit.
REQ-008 blank  input  N_DIGITS  per-digit blank, 1 = digit dark.
REQ-009 lz_suppress  input  1  leading-zero suppression enable.
REQ-010 brightness  input  PWM_W  display duty control.
REQ-011 load  input  1  single-cycle strobe; captures value/dp/blank into staging.
REQ-012 load_ack  output  1  one-cycle pulse when staging is committed to the active display.
REQ-013 frame_start  output  1  one-cycle pulse when digit 0 becomes the scanned digit.
REQ-014 an  output  N_DIGITS  active-low anodes, an[i] drives digit i.
REQ-015 cathodes  output  8  active-low {Ca,Cb,Cc,Cd,Ce,Cf,Cg,Dp}.

Function
REQ-016 Prescaler: PRESCALE_W-bit free-running counter; tick = counter all ones.
REQ-017 Digit index: increments on tick; wraps from N_DIGITS-1 to 0 (non-power-of-2 counts never visit N_DIGITS..2^k-1).
REQ-018 Frame boundary = tick with index == N_DIGITS-1; frame_start pulses in the cycle after it.
REQ-019 load: staging <= {value,dp,blank}, pending <= 1; a second load before commit overwrites staging; only one load_ack results.
REQ-020 Commit: at a frame boundary with pending = 1, active <= staging, pending <= 0, load_ack pulses the next cycle.
REQ-021 load coincident with a committing boundary: old staging commits, new data enters staging, pending stays 1; commits at the next boundary.
REQ-022 load at a boundary with pending = 0: no commit that boundary; commits at the following boundary.
REQ-023 Segment decode: active hex table 0-F (0=8'b0000001x ... F=8'b0111000x, a..g order); Dp bit = ~active_dp[index].
REQ-024 Leading-zero suppression: with lz_suppress = 1, digit i (i >= 1) is dark when active nibbles i..N_DIGITS-1 are all zero and active_dp[i] = 0; digit 0 is never suppressed.
REQ-025 PWM phase = prescaler[PRESCALE_W-1 -: PWM_W]; digit enabled when brightness == all ones or phase < brightness; brightness 0 = always dark.
REQ-026 an[index] = 0 only when the digit is enabled per REQ-025 and not blanked or suppressed; all other an bits 1.
REQ-027 an and cathodes are registered; they reflect the index/phase of the previous cycle (latency 1 clock); dark digit drives cathodes = 8'hFF.
REQ-028 At most one an bit is low in any cycle.
REQ-029 brightness and lz_suppress are used live (not staged).

Reset
REQ-030 Reset asserted: prescaler 0, index 0, pending 0, staging and active value 0, dp 0, blank all ones.
REQ-031 Reset outputs: an all ones, cathodes 8'hFF, load_ack 0, frame_start 0.
REQ-032 Reset mid-frame or with pending = 1 discards pending data; no load_ack follows.

Verification (N_DIGITS=6, PRESCALE_W=4, PWM_W=2 unless stated)
REQ-033 Reset, no load -> an = 6'b111111, cathodes = 8'hFF for 200 cycles; frame_start every 96 cycles.
REQ-034 load value=24'h12A0F3, blank=0, dp=6'b000100, brightness=3 -> load_ack 1 cycle after next boundary; digit 0 shows 3 (0000110 1), digit 2 shows 0 with Dp lit (8'b00000010).
REQ-035 Two loads (24'h111111 then 24'h222222) within one frame -> exactly one load_ack; display shows 2 on all digits.
REQ-036 lz_suppress=1, value=24'h000050, dp=0 -> digits 5..2 dark, digits 1 and 0 show 5 and 0; set dp[3]=1 -> digit 3 shows 0 with Dp.
REQ-037 brightness=1 -> each anode low 4 of every 16 cycles of its slot; brightness=0 -> an all ones.
REQ-038 Reset asserted while pending=1 mid-frame -> outputs return to reset values next edge, no load_ack, display dark after release.
